// File: rtl/ws2812_rz_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ws2812_rz_decoder : WS2812 RZ line receiver, high-time bit slicer, 24-bit words
// Revision 1.0
// ---------------------------------------------------------------------------
module ws2812_rz_decoder #(
  parameter int T_GLITCH   = 4,
  parameter int T_THRESH   = 27,
  parameter int T_HIGH_MAX = 60,
  parameter int T_RESET    = 2500,
  parameter int CNT_W      = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RZ_data,
  output logic [23:0] RGB,
  output logic        data_valid,
  output logic        frame_end,
  output logic        bit_err,
  output logic [15:0] pixel_cnt
);

  localparam logic [1:0] SYNC = 2'd0;
  localparam logic [1:0] IDLE = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] LOW  = 2'd3;

  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(T_RESET - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(T_HIGH_MAX - 1);
  localparam logic [CNT_W-1:0] GLITCH_MIN = CNT_W'(T_GLITCH);
  localparam logic [CNT_W-1:0] THRESH     = CNT_W'(T_THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             meta;
  logic             rz_s;
  logic             rz_d;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [23:0]      shreg;
  logic [4:0]       bidx;
  logic             new_bit;
  logic [23:0]      shifted;

  // cnt holds the high length while in HIGH, so the slicer is a plain compare
  assign new_bit = (cnt >= THRESH);
  assign shifted = {shreg[22:0], new_bit};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta       <= 1'b0;
      rz_s       <= 1'b0;
      rz_d       <= 1'b0;
      state      <= SYNC;
      cnt        <= '0;
      shreg      <= '0;
      bidx       <= '0;
      RGB        <= '0;
      data_valid <= 1'b0;
      frame_end  <= 1'b0;
      bit_err    <= 1'b0;
      pixel_cnt  <= '0;
    end else begin
      meta       <= RZ_data;
      rz_s       <= meta;
      rz_d       <= rz_s;
      data_valid <= 1'b0;
      frame_end  <= 1'b0;
      bit_err    <= 1'b0;

      case (state)
        SYNC: begin
          if (rz_s) begin
            cnt <= '0;
          end else if (cnt == RESET_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        IDLE: begin
          if (rz_s && !rz_d) begin
            cnt   <= CNT_ONE;
            state <= HIGH;
          end
        end

        HIGH: begin
          if (rz_s) begin
            if (cnt == HIGH_LAST) begin
              bit_err <= 1'b1;
              bidx    <= '0;
              cnt     <= '0;
              state   <= SYNC;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (cnt < GLITCH_MIN) begin
            bit_err <= 1'b1;
            bidx    <= '0;
            cnt     <= '0;
            state   <= SYNC;
          end else begin
            shreg <= shifted;
            if (bidx == 5'd23) begin
              RGB        <= shifted;
              data_valid <= 1'b1;
              bidx       <= '0;
              if (pixel_cnt != 16'hFFFF) pixel_cnt <= pixel_cnt + 1'b1;
            end else begin
              bidx <= bidx + 1'b1;
            end
            cnt   <= CNT_ONE;
            state <= LOW;
          end
        end

        LOW: begin
          if (rz_s) begin
            cnt   <= CNT_ONE;
            state <= HIGH;
          end else if (cnt == RESET_LAST) begin
            // latch gap: a nonzero bit index means the word was cut short
            frame_end <= 1'b1;
            bit_err   <= (bidx != 5'd0);
            bidx      <= '0;
            pixel_cnt <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= SYNC;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_rz_decoder.sv
`default_nettype none
// Directed bench for ws2812_rz_decoder: scoreboard of expected words checked on data_valid.
module tb_ws2812_rz_decoder;

  localparam int T_RESET = 2500;
  localparam int GAP     = 2600;

  typedef struct {
    logic [23:0] rgb;
    logic [15:0] pix;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RZ_data = 1'b0;
  logic [23:0] RGB;
  logic        data_valid;
  logic        frame_end;
  logic        bit_err;
  logic [15:0] pixel_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int last_dv = 0;
  int last_fe = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int be_cnt = 0;
  int both_cnt = 0;
  int clash_cnt = 0;
  logic [15:0] exp_pix = 16'd0;
  exp_t sb[$];

  ws2812_rz_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RZ_data    (RZ_data),
    .RGB        (RGB),
    .data_valid (data_valid),
    .frame_end  (frame_end),
    .bit_err    (bit_err),
    .pixel_cnt  (pixel_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard consumer and event counters
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        dv_cnt++;
        last_dv = cyc;
        if (sb.size() == 0) begin
          check("dv_expected", 32'(sb.size() != 0), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rgb", {8'h0, RGB}, {8'h0, e.rgb});
          check("pixel_cnt", {16'h0, pixel_cnt}, {16'h0, e.pix});
        end
      end
      if (frame_end) begin
        fe_cnt++;
        last_fe = cyc;
      end
      if (bit_err) be_cnt++;
      if (frame_end && bit_err) both_cnt++;
      if (frame_end && data_valid) clash_cnt++;
    end
  end

  task automatic send_bit(input int h, input int l);
    RZ_data = 1'b1;
    repeat (h) @(negedge clk);
    RZ_data = 1'b0;
    fall_cyc = cyc;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (v[i]) send_bit(35, 27);
      else      send_bit(18, 44);
    end
  endtask

  task automatic push_word(input logic [23:0] w);
    exp_t e;
    if (exp_pix != 16'hFFFF) exp_pix = exp_pix + 16'd1;
    e.rgb = w;
    e.pix = exp_pix;
    sb.push_back(e);
  endtask

  task automatic gap(input int n);
    RZ_data = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int fe0, be0, dv0, both0, d;
    // reset
    rst_n = 1'b0;
    RZ_data = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_rgb", {8'h0, RGB}, 32'h0);
    check("rst_dv", {31'h0, data_valid}, 32'h0);
    check("rst_fe", {31'h0, frame_end}, 32'h0);
    check("rst_be", {31'h0, bit_err}, 32'h0);
    check("rst_pix", {16'h0, pixel_cnt}, 32'h0);
    rst_n = 1'b1;

    // initial SYNC gap: no frame_end from SYNC
    gap(GAP);
    check("sync_no_fe", 32'(fe_cnt), 32'd0);

    // single word, then latch gap
    push_word(24'hA53CF0);
    send_bits(24'hA53CF0, 24);
    check("dv_latency", 32'(last_dv - fall_cyc), 32'd3);
    gap(GAP);
    exp_pix = 16'd0;
    d = last_fe - fall_cyc;
    check("fe_delay_window", 32'(d >= T_RESET && d <= T_RESET + 3), 32'd1);
    check("fe_count1", 32'(fe_cnt), 32'd1);
    check("pix_after_fe", {16'h0, pixel_cnt}, 32'h0);
    check("dv_count1", 32'(dv_cnt), 32'd1);
    check("no_bit_err1", 32'(be_cnt), 32'd0);

    // back-to-back words
    push_word(24'hFFFFFF);
    send_bits(24'hFFFFFF, 24);
    push_word(24'h000000);
    send_bits(24'h000000, 24);
    gap(GAP);
    exp_pix = 16'd0;
    check("dv_count3", 32'(dv_cnt), 32'd3);
    check("fe_count2", 32'(fe_cnt), 32'd2);
    check("no_bit_err2", 32'(be_cnt), 32'd0);

    // threshold boundaries inside one word: 26->0, 27->1, 4->0, 59->1
    push_word(24'h5ABCDE);
    send_bit(26, 30);
    send_bit(27, 30);
    send_bit(4, 30);
    send_bit(59, 30);
    send_bits(24'h0ABCDE, 20);
    gap(GAP);
    exp_pix = 16'd0;
    check("no_bit_err3", 32'(be_cnt), 32'd0);
    check("fe_count3", 32'(fe_cnt), 32'd3);

    // partial word at a gap
    fe0 = fe_cnt; be0 = be_cnt; dv0 = dv_cnt; both0 = both_cnt;
    send_bits(24'h0002AB, 10);
    gap(GAP);
    check("partial_both", 32'(both_cnt - both0), 32'd1);
    check("partial_fe", 32'(fe_cnt - fe0), 32'd1);
    check("partial_be", 32'(be_cnt - be0), 32'd1);
    check("partial_no_dv", 32'(dv_cnt - dv0), 32'd0);
    check("partial_rgb_hold", {8'h0, RGB}, 32'h5ABCDE);

    // glitch pulse: ignored bits until a full SYNC gap
    fe0 = fe_cnt; be0 = be_cnt;
    send_bit(2, 30);
    check("glitch_be", 32'(be_cnt - be0), 32'd1);
    send_bits(24'h777777, 24);
    gap(GAP);
    check("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_be_once", 32'(be_cnt - be0), 32'd1);
    push_word(24'h123456);
    send_bits(24'h123456, 24);
    gap(GAP);
    exp_pix = 16'd0;

    // stuck-high line
    fe0 = fe_cnt; be0 = be_cnt;
    send_bit(100, 30);
    check("stuck_be", 32'(be_cnt - be0), 32'd1);
    send_bits(24'h3C3C3C, 24);
    gap(GAP);
    check("stuck_no_fe", 32'(fe_cnt - fe0), 32'd0);
    check("stuck_be_once", 32'(be_cnt - be0), 32'd1);
    push_word(24'h0F0F0F);
    send_bits(24'h0F0F0F, 24);
    gap(GAP);
    exp_pix = 16'd0;

    // reset in the middle of a word
    send_bits(24'h000ABC, 12);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_rgb", {8'h0, RGB}, 32'h0);
    check("midrst_pix", {16'h0, pixel_cnt}, 32'h0);
    check("midrst_dv", {31'h0, data_valid}, 32'h0);
    check("midrst_fe", {31'h0, frame_end}, 32'h0);
    check("midrst_be", {31'h0, bit_err}, 32'h0);
    rst_n = 1'b1;
    dv0 = dv_cnt;
    send_bits(24'h000DEF, 12);
    gap(GAP);
    check("midrst_ignored", 32'(dv_cnt - dv0), 32'd0);
    exp_pix = 16'd0;
    push_word(24'hC0FFEE);
    send_bits(24'hC0FFEE, 24);
    gap(GAP);

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("dv_total", 32'(dv_cnt), 32'd7);
    check("dv_fe_clash", 32'(clash_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
